// File: rtl/uart_clk_gen.sv
// Baud-rate enable generator: rx_clk_en at OVERSAMPLE x baud, tx_clk_en at baud.
// The tx strobe coincides with every OVERSAMPLE-th rx strobe, so the two stay phase-locked.
module uart_clk_gen #(
  parameter int CLK_FREQ        = 50_000_000,
  parameter int OVERSAMPLE      = 16,
  parameter int BAUD_RATES [16] = '{300, 600, 1200, 2400, 4800, 9600, 14400, 19200,
                                    28800, 38400, 57600, 115200, 230400, 460800,
                                    921600, 1000000}
) (
  input  logic       clk,
  input  logic       arst,
  input  logic       active,
  input  logic [3:0] baud_rate,
  output logic       tx_clk_en,
  output logic       rx_clk_en
);

  typedef int div_tab_t [16];

  function automatic div_tab_t calc_div();
    div_tab_t t;
    longint   den;
    for (int i = 0; i < 16; i++) begin
      den  = longint'(OVERSAMPLE) * longint'(BAUD_RATES[i]);
      t[i] = int'((longint'(CLK_FREQ) + den / 2) / den);
    end
    return t;
  endfunction

  function automatic int calc_max(div_tab_t t);
    int m;
    m = 0;
    for (int i = 0; i < 16; i++) begin
      if (t[i] > m) m = t[i];
    end
    return m;
  endfunction

  localparam div_tab_t RX_DIV  = calc_div();
  localparam int       MAX_DIV = calc_max(RX_DIV);
  localparam int       CNT_W   = $clog2(MAX_DIV);
  localparam int       OS_W    = $clog2(OVERSAMPLE);
  localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);

  // A divisor below 2 would let a strobe stay high on consecutive cycles.
  for (genvar g = 0; g < 16; g++) begin : g_div_chk
    if (RX_DIV[g] < 2) begin : g_bad
      $error("uart_clk_gen: RX_DIV[%0d] = %0d is below 2", g, RX_DIV[g]);
    end
  end

  logic [3:0]       baud_q, baud_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [OS_W-1:0]  os_q, os_d;
  logic             rx_en_q, rx_en_d;
  logic             tx_en_q, tx_en_d;
  logic [CNT_W-1:0] div_m1;

  assign div_m1 = CNT_W'(RX_DIV[baud_q] - 1);

  always_comb begin
    baud_d  = baud_rate;
    cnt_d   = cnt_q;
    os_d    = os_q;
    rx_en_d = 1'b0;
    tx_en_d = 1'b0;
    if (!active || (baud_rate != baud_q)) begin
      cnt_d = '0;
      os_d  = '0;
    end else if (cnt_q >= div_m1) begin
      // >= rather than == so a stale count above the new terminal value still wraps.
      cnt_d   = '0;
      rx_en_d = 1'b1;
      tx_en_d = (os_q == OS_LAST);
      os_d    = (os_q == OS_LAST) ? '0 : os_q + OS_W'(1);
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      baud_q  <= '0;
      cnt_q   <= '0;
      os_q    <= '0;
      rx_en_q <= 1'b0;
      tx_en_q <= 1'b0;
    end else begin
      baud_q  <= baud_d;
      cnt_q   <= cnt_d;
      os_q    <= os_d;
      rx_en_q <= rx_en_d;
      tx_en_q <= tx_en_d;
    end
  end

  assign rx_clk_en = rx_en_q;
  assign tx_clk_en = tx_en_q;

endmodule

// File: tb/tb_uart_clk_gen.sv
// Bench for uart_clk_gen: expected strobe edges are queued when stimulus is applied
// and consumed as the DUT strobes; any strobe off-schedule, or missing, is flagged.
module tb_uart_clk_gen;

  logic       clk = 1'b0;
  logic       arst;
  logic       active;
  logic [3:0] baud_rate;
  logic       tx_clk_en;
  logic       rx_clk_en;

  int         checks   = 0;
  int         failures = 0;
  int         edge_n   = 0;
  int         exp_rx[$];
  int         exp_tx[$];
  logic [3:0] rx_cnt4;

  // Rounded CLK_FREQ / (16 * baud) for 50 MHz, worked out by hand.
  localparam int DIV [16] = '{10417, 5208, 2604, 1302, 651, 326, 217, 163,
                              109, 81, 54, 27, 14, 7, 3, 3};

  always #10 clk = ~clk;

  uart_clk_gen dut (
    .clk       (clk),
    .arst      (arst),
    .active    (active),
    .baud_rate (baud_rate),
    .tx_clk_en (tx_clk_en),
    .rx_clk_en (rx_clk_en)
  );

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s edge=%0d observed=%b expected=%b", tag, edge_n, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s edge=%0d observed=%0d expected=%0d", tag, edge_n, obs, exp);
    end
  endtask

  // Strobes become visible right after edge base + k*div.
  task automatic push_exp(input int base, input int div, input int nrx);
    for (int k = 1; k <= nrx; k++) begin
      exp_rx.push_back(base + k * div);
      if (k % 16 == 0) exp_tx.push_back(base + k * div);
    end
  endtask

  task automatic run_cycles(input int n);
    bit hit_rx;
    bit hit_tx;
    repeat (n) begin
      @(posedge clk);
      edge_n++;
      @(negedge clk);
      hit_rx = (exp_rx.size() > 0) && (exp_rx[0] == edge_n);
      hit_tx = (exp_tx.size() > 0) && (exp_tx[0] == edge_n);
      if (rx_clk_en !== 1'b0 || hit_rx) begin
        check_bit("rx_strobe", rx_clk_en, hit_rx);
        if (hit_rx) void'(exp_rx.pop_front());
        if (rx_clk_en === 1'b1) rx_cnt4++;
      end
      if (tx_clk_en !== 1'b0 || hit_tx) begin
        check_bit("tx_strobe", tx_clk_en, hit_tx);
        if (hit_tx) void'(exp_tx.pop_front());
        if (tx_clk_en === 1'b1) check_int("rx_count_wrap", int'(rx_cnt4), 0);
      end
    end
  endtask

  task automatic expect_drained(input string tag);
    check_int({tag, "_rx_left"}, exp_rx.size(), 0);
    check_int({tag, "_tx_left"}, exp_tx.size(), 0);
  endtask

  task automatic start_rate(input int idx, input int nrx);
    arst      = 1'b1;
    active    = 1'b0;
    baud_rate = 4'(idx);
    #1;
    check_bit("sweep_rst_rx", rx_clk_en, 1'b0);
    check_bit("sweep_rst_tx", tx_clk_en, 1'b0);
    run_cycles(2);
    arst = 1'b0;
    run_cycles(2);
    active  = 1'b1;
    rx_cnt4 = '0;
    push_exp(edge_n, DIV[idx], nrx);
    run_cycles(nrx * DIV[idx]);
    expect_drained("sweep");
  endtask

  initial begin
    arst      = 1'b1;
    active    = 1'b0;
    baud_rate = 4'd0;
    rx_cnt4   = '0;
    #1;
    check_bit("reset_rx", rx_clk_en, 1'b0);
    check_bit("reset_tx", tx_clk_en, 1'b0);
    run_cycles(2);

    // 9600 baud from a clean start: 17 rx periods, one tx.
    arst      = 1'b0;
    baud_rate = 4'd5;
    run_cycles(2);
    active  = 1'b1;
    rx_cnt4 = '0;
    push_exp(edge_n, DIV[5], 17);
    run_cycles(17 * DIV[5]);
    expect_drained("b9600");

    // Rate change while running: counters restart from the change edge.
    baud_rate = 4'd11;
    rx_cnt4   = '0;
    push_exp(edge_n + 1, DIV[11], 32);
    run_cycles(1 + 32 * DIV[11]);
    expect_drained("b115200");

    // active dropped mid-period, then restored.
    push_exp(edge_n, DIV[11], 3);
    run_cycles(3 * DIV[11] + 10);
    expect_drained("pre_idle");
    active = 1'b0;
    run_cycles(100);
    active  = 1'b1;
    rx_cnt4 = '0;
    push_exp(edge_n, DIV[11], 17);
    run_cycles(17 * DIV[11]);
    expect_drained("reenable");

    // Slow rate mid-count, then switch to index 14.
    baud_rate = 4'd0;
    run_cycles(500);
    baud_rate = 4'd14;
    rx_cnt4   = '0;
    push_exp(edge_n + 1, DIV[14], 16);
    run_cycles(1 + 16 * DIV[14]);
    expect_drained("b921600");

    // Both strobes are high now; reset must clear them without a clock edge.
    check_bit("pre_arst_rx", rx_clk_en, 1'b1);
    check_bit("pre_arst_tx", tx_clk_en, 1'b1);
    arst = 1'b1;
    #1;
    check_bit("arst_async_rx", rx_clk_en, 1'b0);
    check_bit("arst_async_tx", tx_clk_en, 1'b0);
    run_cycles(3);

    for (int i = 0; i < 16; i++) begin
      start_rate(i, (i < 5) ? 2 : 16);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
